// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sequencer states,
// init-value generation and the bypass-select rule used by every read port.
package regfile_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Entry 0 is forced to zero when it is hardwired, whatever the init mode.
    function automatic logic [31:0] init_value(
        input logic [31:0] index,
        input logic        mode,
        input logic        zero_reg
    );
        logic [31:0] val;
        val = 32'd0;
        if (mode && !(zero_reg && index == 32'd0)) begin
            val = index;
        end
        return val;
    endfunction

    function automatic logic bypass_sel(
        input logic        we,
        input logic        rd_writable,
        input logic [31:0] rd,
        input logic [31:0] rs
    );
        return we && rd_writable && (rd == rs);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux plus same-cycle write bypass,
// forced to zero while the init sweep is running.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic                 busy,
    input  logic [AW-1:0]        rs,
    input  logic [NREG*XLEN-1:0] array_flat,
    input  logic                 we,
    input  logic                 rd_writable,
    input  logic [AW-1:0]        rd,
    input  logic [XLEN-1:0]      wdata,
    output logic [XLEN-1:0]      rdata
);

    always_comb begin
        rdata = '0;
        if (!busy) begin
            if ((ZERO_REG != 0) && (rs == '0)) begin
                rdata = '0;
            end else if (bypass_sel(we, rd_writable, 32'(rd), 32'(rs))) begin
                rdata = wdata;
            end else begin
                rdata = array_flat[int'(rs)*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write port, NREAD combinational read ports,
// and an init sequencer that sweeps every entry after reset.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int AW        = $clog2(NREG),
    parameter int NREAD     = 2,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  we,
    output logic                  busy,
    output logic                  wr_drop
);

    state_t             state_reg;
    logic [AW-1:0]      init_ptr_reg;
    logic               busy_reg;
    logic               wr_drop_reg;
    logic [XLEN-1:0]    regs [NREG];

    logic               rd_writable;
    logic               arr_we;
    logic [AW-1:0]      arr_addr;
    logic [XLEN-1:0]    arr_data;
    logic [XLEN-1:0]    init_val;
    logic [NREG*XLEN-1:0] array_flat;

    assign init_val    = XLEN'(init_value(32'(init_ptr_reg), INIT_MODE != 0, ZERO_REG != 0));
    assign rd_writable = !((ZERO_REG != 0) && (rd == '0));

    // Single write port shared by the init sweep and the external writer;
    // the sweep owns it for the whole of INIT, and reset blocks both.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = rd;
        arr_data = wdata;
        if (!rst) begin
            if (state_reg == INIT) begin
                arr_we   = 1'b1;
                arr_addr = init_ptr_reg;
                arr_data = init_val;
            end else if (we && rd_writable) begin
                arr_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            regs[arr_addr] <= arr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= INIT;
            init_ptr_reg <= '0;
            busy_reg     <= 1'b1;
            wr_drop_reg  <= 1'b0;
        end else begin
            wr_drop_reg <= we && busy_reg;
            case (state_reg)
                INIT: begin
                    init_ptr_reg <= init_ptr_reg + AW'(1);
                    if (init_ptr_reg == AW'(NREG - 1)) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                    state_reg <= INIT;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
            assign array_flat[gi*XLEN +: XLEN] = regs[gi];
        end

        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
            regfile_read_port #(
                .XLEN     (XLEN),
                .NREG     (NREG),
                .AW       (AW),
                .ZERO_REG (ZERO_REG)
            ) u_read_port (
                .busy        (busy_reg),
                .rs          (rs[gi*AW +: AW]),
                .array_flat  (array_flat),
                .we          (we),
                .rd_writable (rd_writable),
                .rd          (rd),
                .wdata       (wdata),
                .rdata       (rdata[gi*XLEN +: XLEN])
            );
        end
    endgenerate

    assign busy    = busy_reg;
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default build, ZERO_REG=0 build and
// a narrow 16x32 four-port build, all clocked together from one reset.
module tb_regfile_multiport;

    logic clk;
    logic rst;

    // d0: defaults
    logic [9:0]   rs0;
    logic [127:0] rdata0;
    logic [4:0]   rd0;
    logic [63:0]  wdata0;
    logic         we0, busy0, wr_drop0;
    // d1: ZERO_REG=0
    logic [9:0]   rs1;
    logic [127:0] rdata1;
    logic [4:0]   rd1;
    logic [63:0]  wdata1;
    logic         we1, busy1, wr_drop1;
    // d2: NREG=16, NREAD=4, XLEN=32, INIT_MODE=0
    logic [15:0]  rs2;
    logic [127:0] rdata2;
    logic [3:0]   rd2;
    logic [31:0]  wdata2;
    logic         we2, busy2, wr_drop2;

    regfile_multiport u_dut0 (
        .clk(clk), .rst(rst), .rs(rs0), .rdata(rdata0), .rd(rd0),
        .wdata(wdata0), .we(we0), .busy(busy0), .wr_drop(wr_drop0)
    );

    regfile_multiport #(.ZERO_REG(0)) u_dut1 (
        .clk(clk), .rst(rst), .rs(rs1), .rdata(rdata1), .rd(rd1),
        .wdata(wdata1), .we(we1), .busy(busy1), .wr_drop(wr_drop1)
    );

    regfile_multiport #(.XLEN(32), .NREG(16), .NREAD(4), .INIT_MODE(0)) u_dut2 (
        .clk(clk), .rst(rst), .rs(rs2), .rdata(rdata2), .rd(rd2),
        .wdata(wdata2), .we(we2), .busy(busy2), .wr_drop(wr_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        logic [63:0] v;
        v = '0;
        case (sel)
            0:  v = rdata0[63:0];
            1:  v = rdata0[127:64];
            2:  v = 64'(busy0);
            3:  v = 64'(wr_drop0);
            10: v = rdata1[63:0];
            11: v = rdata1[127:64];
            12: v = 64'(busy1);
            13: v = 64'(wr_drop1);
            20: v = 64'(rdata2[31:0]);
            21: v = 64'(rdata2[63:32]);
            22: v = 64'(rdata2[95:64]);
            23: v = 64'(rdata2[127:96]);
            24: v = 64'(busy2);
            25: v = 64'(wr_drop2);
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Compare everything queued for this cycle at the falling edge, then
    // advance to just past the next rising edge for new stimulus.
    task automatic settle();
        sb_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rs0 = '0; rd0 = '0; wdata0 = '0; we0 = 1'b0;
        rs1 = '0; rd1 = '0; wdata1 = '0; we1 = 1'b0;
        rs2 = '0; rd2 = '0; wdata2 = '0; we2 = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) begin
            sb_push("rst_busy0", 2, 64'd1);
            sb_push("rst_drop0", 3, 64'd0);
            sb_push("rst_busy2", 24, 64'd1);
            sb_push("rst_rd0", 0, 64'd0);
            settle();
        end

        // Initial sweep with default-size and 16-entry builds running together
        rst = 1'b0;
        rs0 = {5'd31, 5'd5};
        rs1 = {5'd31, 5'd5};
        rs2 = {4{4'd9}};
        for (int c = 1; c <= 33; c++) begin
            sb_push($sformatf("sweep_busy0_c%0d", c), 2, 64'(c <= 32));
            sb_push($sformatf("sweep_busy1_c%0d", c), 12, 64'(c <= 32));
            sb_push($sformatf("sweep_busy2_c%0d", c), 24, 64'(c <= 16));
            sb_push($sformatf("sweep_rs5_c%0d", c), 0, (c <= 32) ? 64'd0 : 64'd5);
            sb_push($sformatf("sweep_rs31_c%0d", c), 1, (c <= 32) ? 64'd0 : 64'd31);
            sb_push($sformatf("sweep_d1_rs5_c%0d", c), 10, (c <= 32) ? 64'd0 : 64'd5);
            settle();
        end
        sb_push("d2_init_zero", 20, 64'd0);
        settle();

        // Write with same-cycle bypass, then read back from the array
        we0 = 1'b1; rd0 = 5'd7; wdata0 = 64'hDEAD_BEEF_0000_0001;
        rs0 = {5'd8, 5'd7};
        sb_push("bypass_r7", 0, 64'hDEAD_BEEF_0000_0001);
        sb_push("bypass_other_r8", 1, 64'd8);
        settle();
        we0 = 1'b0;
        sb_push("array_r7", 0, 64'hDEAD_BEEF_0000_0001);
        sb_push("array_r8", 1, 64'd8);
        sb_push("run_no_drop", 3, 64'd0);
        settle();

        // Register 0 write: hardwired in d0, ordinary in d1
        we0 = 1'b1; rd0 = 5'd0; wdata0 = '1; rs0 = {5'd0, 5'd0};
        we1 = 1'b1; rd1 = 5'd0; wdata1 = '1; rs1 = {5'd1, 5'd0};
        sb_push("zero_r0_p0", 0, 64'd0);
        sb_push("zero_r0_p1", 1, 64'd0);
        sb_push("nozero_bypass_r0", 10, 64'hFFFF_FFFF_FFFF_FFFF);
        sb_push("nozero_r1", 11, 64'd1);
        settle();
        we0 = 1'b0; we1 = 1'b0;
        sb_push("zero_r0_after", 0, 64'd0);
        sb_push("zero_no_drop", 3, 64'd0);
        sb_push("nozero_r0_after", 10, 64'hFFFF_FFFF_FFFF_FFFF);
        sb_push("nozero_no_drop", 13, 64'd0);
        settle();

        // Four ports on the same register as it is being written
        we2 = 1'b1; rd2 = 4'd9; wdata2 = 32'h1234; rs2 = {4{4'd9}};
        for (int k = 0; k < 4; k++) sb_push($sformatf("p4_bypass_%0d", k), 20 + k, 64'h1234);
        settle();
        we2 = 1'b0; rs2 = {4'd2, 4'd9, 4'd9, 4'd9};
        for (int k = 0; k < 3; k++) sb_push($sformatf("p4_array_%0d", k), 20 + k, 64'h1234);
        sb_push("p4_r2_init0", 23, 64'd0);
        settle();

        // Reset with a write in the same cycle: reset wins, no drop pulse
        rst = 1'b1;
        we0 = 1'b1; rd0 = 5'd3; wdata0 = 64'h77; rs0 = {5'd7, 5'd3};
        sb_push("pre_rst_drop", 3, 64'd0);
        settle();

        // Write during sweep, then reset mid-sweep at cycle 20
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            we0 = (c == 10); rd0 = 5'd3; wdata0 = 64'h55;
            rst = (c == 20);
            sb_push($sformatf("s2_busy0_c%0d", c), 2, 64'd1);
            sb_push($sformatf("s2_busy2_c%0d", c), 24, 64'(c <= 16));
            sb_push($sformatf("s2_drop0_c%0d", c), 3, 64'(c == 11));
            sb_push($sformatf("s2_rd_c%0d", c), 0, 64'd0);
            settle();
        end

        // Full restarted sweep; write on its last cycle is dropped too
        rst = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            we0 = (c == 32); rd0 = 5'd4; wdata0 = 64'h99;
            sb_push($sformatf("s3_busy0_c%0d", c), 2, 64'(c <= 32));
            sb_push($sformatf("s3_busy1_c%0d", c), 12, 64'(c <= 32));
            sb_push($sformatf("s3_busy2_c%0d", c), 24, 64'(c <= 16));
            sb_push($sformatf("s3_drop0_c%0d", c), 3, 64'(c == 33));
            settle();
        end

        // Every entry must hold its init value again
        we0 = 1'b0;
        rs2 = {4{4'd9}};
        sb_push("d2_r9_reinit", 20, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs0 = {5'(31 - i), 5'(i)};
            rs1 = {5'(31 - i), 5'(i)};
            sb_push($sformatf("reinit_d0_r%0d", i), 0, 64'(i));
            sb_push($sformatf("reinit_d0_r%0d", 31 - i), 1, 64'(31 - i));
            sb_push($sformatf("reinit_d1_r%0d", i), 10, 64'(i));
            settle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Clocked writes and combinational reads on NREAD ports.
- Same-cycle write-to-read bypass; optional hardwired-zero register 0.
- After reset, an init sequencer fills the array one entry per cycle. The decode stage reads operands from it, and writeback drives the write port.

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of registers; must be a power of 2, minimum 2.
- AW, $clog2(NREG), address width; derived, do not override.
- NREAD, 2, number of read ports.
- ZERO_REG, 1: register 0 reads as 0 and ignores writes. 0: register 0 is ordinary.
- INIT_MODE, 1: init value of entry i is i, zero-extended to XLEN. 0: all entries init to 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs  in  NREAD*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NREAD*XLEN  read data; port k is bits [k*XLEN +: XLEN]; signed interpretation belongs to consumers.
- rd  in  AW  write address.
- wdata  in  XLEN  write data.
- we  in  1  write enable, sampled on clk.
- busy  out  1  init sweep in progress; array not valid.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded because busy was 1.

Behaviour:
- Reset and init sequencing:
  - rst sampled high: FSM to INIT, init_ptr <= 0, busy <= 1, wr_drop <= 0.
  - While rst stays high, FSM holds INIT with init_ptr = 0; no array writes.
  - First cycle with rst low in INIT: write entry init_ptr with its init value, then increment init_ptr.
  - Sweep takes exactly NREG cycles after rst deasserts. In the cycle where init_ptr = NREG-1 is written, FSM moves to RUN and busy <= 0 at that edge.
  - rst asserted mid-sweep restarts the sweep from 0; entries already written remain but are rewritten.
  - With ZERO_REG=1, entry 0 is written 0 regardless of INIT_MODE.
- States: INIT (busy=1), RUN (busy=0). No other states. Encoding and the init-value function live in the package.
- Reads while busy=1: every rdata port outputs 0, regardless of array contents.
- Reads in RUN (combinational, zero latency):
  - rs=0 with ZERO_REG=1: rdata = 0.
  - Else if we=1, rd==rs and rd is writable: rdata = wdata (bypass).
  - Else rdata = array[rs].
  - Ports are independent; any number may address the same register.
- Writes in RUN:
  - we=1 at the edge: array[rd] <= wdata.
  - With ZERO_REG=1, rd=0 writes are discarded silently: no wr_drop, no bypass.
  - One write per cycle. No read-modify-write hazard, because bypass covers the same-cycle case.
- Writes during INIT:
  - we=1 while busy=1: write discarded; wr_drop=1 on the next cycle.
  - wr_drop is 0 in all other cycles, including every cycle while rst=1.
- Reset values: busy=1 and wr_drop=0 from the first edge with rst=1. All rdata=0 while busy=1.
- Before the first reset, array contents and outputs are undefined. Benches must apply rst.
- Width rules: wdata is stored unmodified. Init value is zero-extended; if NREG > 2^XLEN it is truncated to XLEN bits. No arithmetic on data.
- Simultaneous events:
  - rst and we in the same cycle: rst wins; write discarded; wr_drop stays 0.
  - Last init cycle with we=1: write discarded and wr_drop pulses, because busy was 1 in that cycle.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state enum {INIT, RUN};
  - the init_value(index, mode) function;
  - the bypass-select helper.
- One natural sub-module, regfile_read_port: a single-port combinational read mux plus bypass. It is instantiated NREAD times in a generate loop.
- Sequencer and array stay in the top module.

Test Plan:
- Init sweep, defaults: rst high 3 cycles, then low. Required: busy=1 for exactly 32 cycles after deassert, then 0. With rs0=5, rs1=31, rdata = 0 while busy, then 5 and 31.
- Write then read: in RUN, we=1, rd=7, wdata=0xDEAD_BEEF_0000_0001. Same cycle, rs0=7 reads that value via bypass. Next cycle with we=0, rs0=7 still reads it from the array.
- Zero register: we=1, rd=0, wdata=0xFFFF_FFFF_FFFF_FFFF. Required: rs0=0 reads 0 in that cycle and after; wr_drop=0. Rerun with ZERO_REG=0: reads all-ones.
- Write during init: rst pulse, then we=1, rd=3, wdata=0x55 at sweep cycle 10. Required: wr_drop=1 on the next cycle only. After the sweep, rs0=3 reads 3.
- Reset mid-sweep: assert rst at sweep cycle 20, deassert. Required: busy stays 1 for a full 32 further cycles; contents afterwards equal init values.
- Parametric run: NREG=16, NREAD=4, XLEN=32, INIT_MODE=0. All four ports read rs=9 while we=1, rd=9, wdata=0x1234. Required: all four rdata = 0x1234; busy sweep lasts exactly 16 cycles.
